// File: rtl/dm_strobe_pipe.sv
// MEM-stage data memory: per-byte write strobes, 1/2-cycle read pipe, post-reset clear sweep.
// Define DM_PARITY_EN to add per-byte even parity (DM_pinj / DM_perr ports).
module dm_strobe_pipe #(
    parameter int data_size    = 32,
    parameter int address_size = 15,
    parameter int mem_size     = 2**address_size,
    parameter int read_latency = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      DM_enable,
    input  logic                      DM_read,
    input  logic                      DM_write,
    input  logic [data_size/8-1:0]    DM_wstrb,
    input  logic [address_size-1:0]   DM_address,
    input  logic [data_size-1:0]      DM_in,
`ifdef DM_PARITY_EN
    input  logic                      DM_pinj,
    output logic                      DM_perr,
`endif
    output logic [data_size-1:0]      DM_out,
    output logic                      DM_valid,
    output logic                      DM_ready
);
    localparam int nb = data_size / 8;
    localparam logic [address_size-1:0] last_addr = address_size'(mem_size - 1);
    localparam logic [address_size:0]   mem_words = (address_size + 1)'(mem_size);
`ifdef DM_PARITY_EN
    localparam int pw = data_size + 1;
`else
    localparam int pw = data_size;
`endif

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state, state_nxt;
    logic [address_size-1:0] clr_cnt;
    logic [data_size-1:0]    mem [mem_size];
    logic                    in_range, acc, acc_rd, acc_wr;
    logic [data_size-1:0]    rd_word;
    logic [pw-1:0]           rd_pay, s1_pay;
    logic                    s1_valid;

    // NOTE: state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // NOTE: defaults first so no path through always_comb can infer a latch.
    always_comb begin
        state_nxt = state;
        DM_ready  = 1'b0;
        case (state)
            CLEAR: if (clr_cnt == last_addr) state_nxt = READY;
            READY: DM_ready = 1'b1;
            default: state_nxt = CLEAR;
        endcase
    end

    assign in_range = {1'b0, DM_address} < mem_words;
    assign acc      = DM_ready & DM_enable & (DM_read | DM_write);
    assign acc_rd   = acc & DM_read;
    assign acc_wr   = acc & ~DM_read & DM_write;

    // NOTE: the array has no reset; only the sweep zeroes it, keeping it RAM-inferable.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (acc_wr && in_range) begin
            for (int k = 0; k < nb; k++)
                if (DM_wstrb[k]) mem[DM_address][8*k +: 8] <= DM_in[8*k +: 8];
        end
    end

    always_comb begin
        rd_word = '0;
        if (in_range) rd_word = mem[DM_address];
    end

`ifdef DM_PARITY_EN
    logic [nb-1:0] par [mem_size];
    logic          rd_perr;

    // Stored bit makes each byte plus parity even; pinj flips it to seed an error.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            par[clr_cnt] <= '0;
        end else if (acc_wr && in_range) begin
            for (int k = 0; k < nb; k++)
                if (DM_wstrb[k]) par[DM_address][k] <= (^DM_in[8*k +: 8]) ^ DM_pinj;
        end
    end

    always_comb begin
        rd_perr = 1'b0;
        if (in_range)
            for (int k = 0; k < nb; k++)
                if ((^mem[DM_address][8*k +: 8]) != par[DM_address][k]) rd_perr = 1'b1;
    end

    assign rd_pay = {rd_perr, rd_word};
`else
    assign rd_pay = rd_word;
`endif

    generate
        if (read_latency == 2) begin : g_lat2
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1_pay   <= '0;
                end else begin
                    s1_valid <= acc_rd;
                    if (acc_rd) s1_pay <= rd_pay;
                end
            end
        end else begin : g_lat1
            assign s1_valid = acc_rd;
            assign s1_pay   = rd_pay;
        end
    endgenerate

    // DM_out holds the last returned word; DM_valid marks the cycle it changed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DM_out   <= '0;
            DM_valid <= 1'b0;
        end else begin
            DM_valid <= s1_valid;
            if (s1_valid) DM_out <= s1_pay[data_size-1:0];
        end
    end

`ifdef DM_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) DM_perr <= 1'b0;
        else     DM_perr <= s1_valid & s1_pay[data_size];
    end
`endif

endmodule

// File: tb/tb_dm_strobe_pipe.sv
// Self-checking bench for dm_strobe_pipe: latency-1 and latency-2 instances share stimulus,
// both compared every cycle against a word/byte-level memory model.
module tb_dm_strobe_pipe;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int MS = 40;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0, rd = 1'b0, wr = 1'b0, pinj = 1'b0;
    logic [NB-1:0] strb = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] out1, out2;
    logic          v1, v2, r1, r2;
`ifdef DM_PARITY_EN
    logic          pe1, pe2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dm_strobe_pipe #(.data_size(DW), .address_size(AW), .mem_size(MS), .read_latency(1)) u_dut1 (
        .clk(clk), .rst(rst), .DM_enable(en), .DM_read(rd), .DM_write(wr), .DM_wstrb(strb),
        .DM_address(addr), .DM_in(din),
`ifdef DM_PARITY_EN
        .DM_pinj(pinj), .DM_perr(pe1),
`endif
        .DM_out(out1), .DM_valid(v1), .DM_ready(r1)
    );

    dm_strobe_pipe #(.data_size(DW), .address_size(AW), .mem_size(MS), .read_latency(2)) u_dut2 (
        .clk(clk), .rst(rst), .DM_enable(en), .DM_read(rd), .DM_write(wr), .DM_wstrb(strb),
        .DM_address(addr), .DM_in(din),
`ifdef DM_PARITY_EN
        .DM_pinj(pinj), .DM_perr(pe2),
`endif
        .DM_out(out2), .DM_valid(v2), .DM_ready(r2)
    );

    // Reference model: plain word array, a per-byte "parity was corrupted" flag,
    // a sweep counter, and a short history of per-cycle read results.
    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic          p;
    } rsp_t;

    logic [DW-1:0] ref_mem [MS];
    logic [NB-1:0] ref_bad [MS];
    int            sweep_cnt = 0;
    rsp_t          hist[$];
    logic [DW-1:0] hold1 = '0, hold2 = '0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        rsp_t r;
        int   a;
        r = '0;
        a = int'(addr);
        if (sweep_cnt < MS) begin
            ref_mem[sweep_cnt] = '0;
            ref_bad[sweep_cnt] = '0;
            sweep_cnt++;
        end else if (en && (rd || wr)) begin
            if (rd) begin
                r.v = 1'b1;
                if (a < MS) begin
                    r.d = ref_mem[a];
                    r.p = |ref_bad[a];
                end
            end else if (a < MS) begin
                for (int k = 0; k < NB; k++)
                    if (strb[k]) begin
                        ref_mem[a][8*k +: 8] = din[8*k +: 8];
                        ref_bad[a][k]        = pinj;
                    end
            end
        end
        hist.push_back(r);
        if (hist.size() > 2) void'(hist.pop_front());
    endtask

    task automatic step();
        rsp_t e1, e2;
        @(posedge clk);
        model_edge();
        #1;
        e1 = hist[1];
        e2 = hist[0];
        if (e1.v) hold1 = e1.d;
        if (e2.v) hold2 = e2.d;
        check("ready_l1", 32'(r1), 32'(sweep_cnt >= MS));
        check("ready_l2", 32'(r2), 32'(sweep_cnt >= MS));
        check("valid_l1", 32'(v1), 32'(e1.v));
        check("valid_l2", 32'(v2), 32'(e2.v));
        check("out_l1", out1, hold1);
        check("out_l2", out2, hold2);
`ifdef DM_PARITY_EN
        check("perr_l1", 32'(pe1), 32'(e1.v & e1.p));
        check("perr_l2", 32'(pe2), 32'(e2.v & e2.p));
`endif
    endtask

    task automatic drive(input logic e, input logic r, input logic w, input logic [NB-1:0] s,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic pi);
        en = e; rd = r; wr = w; strb = s; addr = a; din = d; pinj = pi;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        sweep_cnt = 0;
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
        hold1 = '0;
        hold2 = '0;
        check("rst_out_l1", out1, '0);
        check("rst_out_l2", out2, '0);
        check("rst_valid", 32'({v1, v2}), '0);
        check("rst_ready", 32'({r1, r2}), '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_valid", 32'({v1, v2}), '0);
        rst = 1'b0;
    endtask

    // Idles until ready, checking the sweep takes exactly MS cycles.
    task automatic wait_sweep(input string tag);
        int n = 0;
        while (!r1 && n < 4 * MS) begin
            idle(1);
            n++;
        end
        check(tag, 32'(n), 32'(MS));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // Sweep length and all-zero contents, including out-of-range addresses.
        do_reset();
        wait_sweep("sweep_len");
        for (int a = 0; a < (1 << AW); a++) drive(1, 1, 0, '0, AW'(a), '0, 0);
        idle(2);

        // Byte strobes and read-after-write.
        drive(1, 0, 1, 4'b1111, 6'd3, 32'hDEADBEEF, 0);
        drive(1, 0, 1, 4'b0001, 6'd3, 32'h00001122, 0);
        drive(1, 1, 0, 4'b0000, 6'd3, 32'h0, 0);
        check("t2_data_l1", out1, 32'hDEADBE22);
        idle(1);
        check("t2_data_l2", out2, 32'hDEADBE22);
        idle(1);

        // Back-to-back reads return in order.
        drive(1, 0, 1, 4'b1111, 6'd19, 32'h19191919, 0);
        drive(1, 0, 1, 4'b1111, 6'd28, 32'hA5C3281C, 0);
        drive(1, 1, 0, '0, 6'd3, '0, 0);
        drive(1, 1, 0, '0, 6'd19, '0, 0);
        drive(1, 1, 0, '0, 6'd28, '0, 0);
        idle(2);

        // Read wins over a simultaneous write; strobe 0 and out-of-range writes are no-ops.
        drive(1, 1, 1, 4'b1111, 6'd19, 32'h00000055, 0);
        drive(1, 1, 0, '0, 6'd19, '0, 0);
        drive(1, 0, 1, 4'b0000, 6'd19, 32'hFFFFFFFF, 0);
        drive(1, 0, 1, 4'b1111, 6'd45, 32'h12345678, 0);
        drive(1, 1, 0, '0, 6'd45, '0, 0);
        drive(1, 1, 0, '0, 6'd19, '0, 0);
        drive(0, 1, 0, '0, 6'd19, '0, 0);
        idle(2);

`ifdef DM_PARITY_EN
        drive(1, 0, 1, 4'b0010, 6'd28, 32'h0000AB00, 1);
        drive(1, 1, 0, '0, 6'd28, '0, 0);
        check("t6_perr_set", 32'(pe1), 32'd1);
        idle(2);
        drive(1, 0, 1, 4'b1111, 6'd28, 32'h0BADF00D, 0);
        drive(1, 1, 0, '0, 6'd28, '0, 0);
        check("t6_perr_clr", 32'(pe1), 32'd0);
        idle(2);
`endif

        // Reset mid-sweep, then mid-read; each restarts a full sweep.
        do_reset();
        idle(10);
        do_reset();
        wait_sweep("sweep_restart");
        drive(1, 0, 1, 4'b1111, 6'd7, 32'hCAFEF00D, 0);
        drive(1, 1, 0, '0, 6'd7, '0, 0);
        do_reset();
        wait_sweep("sweep_after_read");
        drive(1, 1, 0, '0, 6'd7, '0, 0);
        idle(2);

        // Randomized traffic on a small hot address set plus occasional out-of-range.
        for (int i = 0; i < 800; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(MS, (1 << AW) - 1))
                                            : AW'($urandom_range(0, 7) * 5);
            drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)), NB'($urandom), a, DW'($urandom),
                  logic'($urandom_range(0, 7) == 0));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
